// File: rtl/ser_frame_rx_pkg.sv
// Shared types, widths and helpers for the serial frame receiver.
package ser_rx_pkg;

    // Good-frame counter width.
    localparam int FRAME_CNT_W = 16;

    // Bits in one frame: address, data and an optional trailing parity bit.
    function automatic int frame_w(input int addr_w, input int data_w, input int parity_en);
        return addr_w + data_w + ((parity_en != 0) ? 1 : 0);
    endfunction

    // The bit counter must hold FRAME_W+1 so that over-length frames saturate
    // one above the legal length instead of wrapping back onto it.
    function automatic int cnt_w(input int frame_bits);
        return $clog2(frame_bits + 2);
    endfunction

    // Counter width for the default 3+16 bit frame without parity.
    localparam int CNT_W = cnt_w(frame_w(3, 16, 0));

    // Verdict on a frame at its closing RX_LOAD edge.
    typedef enum logic [1:0] {
        FRAME_NONE    = 2'd0,
        FRAME_GOOD    = 2'd1,
        FRAME_BAD_LEN = 2'd2,
        FRAME_BAD_PAR = 2'd3
    } frame_res_e;

endpackage

// File: rtl/ser_frame_rx_if.sv
// Serial link inputs and published frame outputs of the frame receiver.
interface ser_frame_rx_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    import ser_rx_pkg::*;

    logic                          RX_DATA;
    logic                          RX_LOAD;
    logic [ADDR_W-1:0]             P_ADDR;
    logic [DATA_W-1:0]             P_DATA;
    logic                          P_ENA;
    logic                          ERR_LEN;
    logic                          ERR_PAR;
    logic [FRAME_CNT_W-1:0]        FRAME_CNT;
    logic [(2**ADDR_W)*DATA_W-1:0] REG_BANK;

    // Link side: drives the serial stream, observes the results.
    modport master (
        output RX_DATA, RX_LOAD,
        input  P_ADDR, P_DATA, P_ENA, ERR_LEN, ERR_PAR, FRAME_CNT, REG_BANK
    );

    // Receiver side.
    modport slave (
        input  RX_DATA, RX_LOAD,
        output P_ADDR, P_DATA, P_ENA, ERR_LEN, ERR_PAR, FRAME_CNT, REG_BANK
    );

endinterface

// File: rtl/ser_frame_rx_shift_core.sv
// Shift register, saturating bit counter and RX_LOAD rising-edge detect.
// Presents the received payload, parity bit and a length check so the
// parent can judge the frame in the cycle of the closing edge.
module ser_shift_core
    import ser_rx_pkg::*;
#(
    parameter int PAYLOAD_W = 19,
    parameter int FRAME_W   = 19,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_data,
    input  logic                 rx_load,
    output logic                 frame_end,
    output logic [PAYLOAD_W-1:0] payload,
    output logic                 par_bit,
    output logic                 length_ok
);

    localparam int              BIT_CNT_W = cnt_w(FRAME_W);
    localparam logic [BIT_CNT_W-1:0] CNT_FRAME = BIT_CNT_W'(FRAME_W);
    localparam logic [BIT_CNT_W-1:0] CNT_SAT   = BIT_CNT_W'(FRAME_W + 1);

    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 load_q, load_d;

    // Only the first cycle of a high RX_LOAD closes a frame.
    assign frame_end = rx_load & ~load_q;
    assign length_ok = (bit_cnt_q == CNT_FRAME);

    // Next state: shift and count on data cycles, clear the count on a frame end.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        load_d    = rx_load;
        if (!rx_load) begin
            if (MSB_FIRST != 0) begin
                shift_d = {shift_q[FRAME_W-2:0], rx_data};
            end else begin
                shift_d = {rx_data, shift_q[FRAME_W-1:1]};
            end
            if (bit_cnt_q != CNT_SAT) begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
        end else if (frame_end) begin
            bit_cnt_d = '0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            load_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            load_q    <= load_d;
        end
    end

    // The parity bit is always the newest bit: bit 0 when shifting left,
    // the top bit when shifting right.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign payload = shift_q[FRAME_W-1 -: PAYLOAD_W];
            assign par_bit = (PARITY_EN != 0) ? shift_q[0] : 1'b0;
        end else begin : g_lsb
            assign payload = shift_q[PAYLOAD_W-1:0];
            assign par_bit = (PARITY_EN != 0) ? shift_q[FRAME_W-1] : 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ser_frame_rx.sv
// Serial frame receiver: judges each frame at its closing RX_LOAD edge,
// publishes good frames with a strobe and mirrors them into a register bank.
module ser_frame_rx
    import ser_rx_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 16,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic           RX_CLK,
    input  logic           RST,
    ser_frame_rx_if.slave  bus
);

    localparam int   PAYLOAD_W = ADDR_W + DATA_W;
    localparam int   FRAME_W   = frame_w(ADDR_W, DATA_W, PARITY_EN);
    localparam int   NSLOT     = 2 ** ADDR_W;
    localparam logic ODD_BIT   = (PARITY_ODD != 0);

    logic                 frame_end;
    logic [PAYLOAD_W-1:0] payload;
    logic                 par_bit;
    logic                 length_ok;
    logic                 parity_ok;
    logic [ADDR_W-1:0]    frame_addr;
    logic [DATA_W-1:0]    frame_data;
    frame_res_e           frame_res;

    logic [ADDR_W-1:0]      p_addr_q, p_addr_d;
    logic [DATA_W-1:0]      p_data_q, p_data_d;
    logic                   p_ena_q, p_ena_d;
    logic                   err_len_q, err_len_d;
    logic                   err_par_q, err_par_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0]      bank_q [NSLOT];
    logic [DATA_W-1:0]      bank_d [NSLOT];

    ser_shift_core #(
        .PAYLOAD_W (PAYLOAD_W),
        .FRAME_W   (FRAME_W),
        .MSB_FIRST (MSB_FIRST),
        .PARITY_EN (PARITY_EN)
    ) u_core (
        .clk       (RX_CLK),
        .rst       (RST),
        .rx_data   (bus.RX_DATA),
        .rx_load   (bus.RX_LOAD),
        .frame_end (frame_end),
        .payload   (payload),
        .par_bit   (par_bit),
        .length_ok (length_ok)
    );

    assign frame_addr = payload[PAYLOAD_W-1 -: ADDR_W];
    assign frame_data = payload[DATA_W-1:0];
    assign parity_ok  = (PARITY_EN == 0) || (((^payload) ^ par_bit) == ODD_BIT);

    // Frame verdict: a length error takes precedence over a parity error.
    always_comb begin
        frame_res = FRAME_NONE;
        if (frame_end) begin
            if (!length_ok) begin
                frame_res = FRAME_BAD_LEN;
            end else if (!parity_ok) begin
                frame_res = FRAME_BAD_PAR;
            end else begin
                frame_res = FRAME_GOOD;
            end
        end
    end

    // Next values of the published outputs; strobes default low, data holds.
    always_comb begin
        p_addr_d    = p_addr_q;
        p_data_d    = p_data_q;
        p_ena_d     = 1'b0;
        err_len_d   = 1'b0;
        err_par_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        bank_d      = bank_q;
        case (frame_res)
            FRAME_GOOD: begin
                p_addr_d           = frame_addr;
                p_data_d           = frame_data;
                p_ena_d            = 1'b1;
                frame_cnt_d        = frame_cnt_q + FRAME_CNT_W'(1);
                bank_d[frame_addr] = frame_data;
            end
            FRAME_BAD_LEN: err_len_d = 1'b1;
            FRAME_BAD_PAR: err_par_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers and shadow bank, all cleared by reset.
    always_ff @(posedge RX_CLK or posedge RST) begin
        if (RST) begin
            p_addr_q    <= '0;
            p_data_q    <= '0;
            p_ena_q     <= 1'b0;
            err_len_q   <= 1'b0;
            err_par_q   <= 1'b0;
            frame_cnt_q <= '0;
            for (int k = 0; k < NSLOT; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            p_addr_q    <= p_addr_d;
            p_data_q    <= p_data_d;
            p_ena_q     <= p_ena_d;
            err_len_q   <= err_len_d;
            err_par_q   <= err_par_d;
            frame_cnt_q <= frame_cnt_d;
            bank_q      <= bank_d;
        end
    end

    assign bus.P_ADDR    = p_addr_q;
    assign bus.P_DATA    = p_data_q;
    assign bus.P_ENA     = p_ena_q;
    assign bus.ERR_LEN   = err_len_q;
    assign bus.ERR_PAR   = err_par_q;
    assign bus.FRAME_CNT = frame_cnt_q;

    // Flatten the bank so slot k sits at [k*DATA_W +: DATA_W].
    always_comb begin
        bus.REG_BANK = '0;
        for (int k = 0; k < NSLOT; k++) begin
            bus.REG_BANK[k*DATA_W +: DATA_W] = bank_q[k];
        end
    end

endmodule
